// File: rtl/memoria_pkg.sv
// Shared constants, word/address types and the power-on image of main memory.
// The cache bench imports the same image so every reference model starts from identical contents.
package memoria_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 3;
    localparam int DEPTH  = 16;

    typedef logic [ADDR_W-1:0] mem_addr_t;
    typedef logic [DATA_W-1:0] mem_word_t;

    localparam mem_word_t MEM_INIT [16] = '{
        3'b111, 3'b011, 3'b100, 3'b111,
        3'b100, 3'b011, 3'b001, 3'b000,
        3'b001, 3'b010, 3'b011, 3'b100,
        3'b101, 3'b111, 3'b000, 3'b000
    };

    // Words beyond the 16-entry image come up as zero in larger configurations.
    function automatic mem_word_t init_word(input int idx);
        mem_word_t w;
        w = '0;
        if (idx >= 0 && idx < 16) begin
            w = MEM_INIT[idx[3:0]];
        end
        return w;
    endfunction

endpackage

// File: rtl/memoria_principal.sv
// Single-port main-memory RAM behind the cache: shared address, one-cycle registered read.
// A write also drives the written word onto q on the same edge; no handshake, one access per cycle.
module memoria_principal
    import memoria_pkg::*;
#(
    parameter int ADDR_W = memoria_pkg::ADDR_W,
    parameter int DATA_W = memoria_pkg::DATA_W,
    parameter int DEPTH  = memoria_pkg::DEPTH
) (
    input  logic [ADDR_W-1:0] address,
    input  logic              clock,
    input  logic [DATA_W-1:0] data,
    input  logic              wren,
    output logic [DATA_W-1:0] q,
    input  logic              reset_n
);

    logic [DATA_W-1:0] mem [DEPTH];

    // An unknown wren falls through to the read branch, so the array is never overwritten by X.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= DATA_W'(init_word(i));
            end
        end else if (wren) begin
            mem[address] <= data;
            q            <= data;
        end else begin
            q <= mem[address];
        end
    end

endmodule

// File: tb/tb_memoria_principal.sv
// Scoreboard bench for memoria_principal: expected q pushed at drive time, popped after the edge.
module tb_memoria_principal;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] address = '0;
    logic [2:0] data    = '0;
    logic       wren    = 1'b0;
    logic [2:0] q;

    memoria_principal dut (
        .address (address),
        .clock   (clock),
        .data    (data),
        .wren    (wren),
        .q       (q),
        .reset_n (reset_n)
    );

    always #5 clock = ~clock;

    localparam logic [2:0] IMG [16] = '{
        3'b111, 3'b011, 3'b100, 3'b111, 3'b100, 3'b011, 3'b001, 3'b000,
        3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b111, 3'b000, 3'b000
    };

    logic [2:0] model [16];
    logic [2:0] sb_q [$];
    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [2:0] got, input logic [2:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic load_image();
        for (int i = 0; i < 16; i++) model[i] = IMG[i];
    endtask

    // Drive one access at the falling edge, predict q, then compare just after the rising edge.
    task automatic op(input string tag, input logic [3:0] a, input logic [2:0] d, input logic we);
        logic [2:0] e;
        @(negedge clock);
        address = a;
        data    = d;
        wren    = we;
        if (we === 1'b1) begin
            model[a] = d;
            e = d;
        end else begin
            e = model[a];
        end
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty, got %b", tag, q);
        end else begin
            check_val(tag, q, sb_q.pop_front());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        load_image();
        #12;
        check_val("reset_q", q, 3'b000);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++) op($sformatf("init_rd%0d", i), 4'(i), 3'b000, 1'b0);

        op("wr5", 4'h5, 3'b110, 1'b1);
        op("rd5", 4'h5, 3'b000, 1'b0);
        op("rd4", 4'h4, 3'b000, 1'b0);

        op("wb_wrB", 4'hB, 3'b010, 1'b1);
        op("wb_rd3", 4'h3, 3'b000, 1'b0);
        op("wb_rdB", 4'hB, 3'b000, 1'b0);

        op("b2b_wr7a", 4'h7, 3'b001, 1'b1);
        op("b2b_wr7b", 4'h7, 3'b101, 1'b1);
        op("b2b_rd7", 4'h7, 3'b000, 1'b0);

        op("xwren", 4'h6, 3'b111, 1'bx);
        op("xwren_rd6", 4'h6, 3'b000, 1'b0);

        for (int i = 0; i < 4; i++) op($sformatf("hold%0d", i), 4'h9, 3'b000, 1'b0);
        #3;
        check_val("hold_between_edges", q, 3'b010);

        for (int i = 0; i < 40; i++) begin
            op($sformatf("rand%0d", i), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)));
        end

        op("pre_rst_wr2", 4'h2, 3'b111, 1'b1);
        op("pre_rst_wrC", 4'hC, 3'b110, 1'b1);
        @(negedge clock);
        address = 4'h5;
        data    = 3'b111;
        wren    = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check_val("async_rst_q", q, 3'b000);
        load_image();
        @(posedge clock);
        #1;
        check_val("rst_hold_q", q, 3'b000);
        @(negedge clock);
        wren    = 1'b0;
        reset_n = 1'b1;
        op("post_rst_rd5", 4'h5, 3'b000, 1'b0);
        op("post_rst_rdC", 4'hC, 3'b000, 1'b0);
        op("post_rst_rd2", 4'h2, 3'b000, 1'b0);
        op("post_rst_rdF", 4'hF, 3'b000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memoria_principal.md
Name: memoria_principal

Overview:
- Single-port synchronous main-memory RAM backing the 2-way set-associative cache: 16 words × 3 bits, one shared address for reads and writes.
- The cache drives the address, write data and write enable; the RAM accepts write-backs from the cache and returns read data for line fills.
- Inputs are sampled on the rising clock edge. The cache consumes `q` on the following falling edge.

Parameters:
- ADDR_W, 4, address width in bits.
- DATA_W, 3, word width in bits.
- DEPTH, 16, number of words; must equal 2**ADDR_W.

Ports:
- clock  in  1  system clock; all sampling on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  ADDR_W  word address {tag[1:0], index[1:0]} supplied by the cache.
- data  in  DATA_W  write data (cache write-back word).
- wren  in  1  1 = write data to address on this edge; 0 = read.
- q  out  DATA_W  registered read data.
- Positional order after reset_n matches the existing instantiation: address, clock, data, wren, q (reset_n appended last in positional use).

Behaviour:
- Storage: DEPTH × DATA_W array of flops, fully resettable.
- Reset (reset_n low, asynchronous, takes effect without a clock edge):
  - q = 0.
  - Array loads the default image: word0..15 = 111,011,100,111,100,011,001,000,001,010,011,100,101,111,000,000.
  - If DEPTH ≠ 16, words ≥ 16 reset to 0.
- Rising edge with reset_n high, wren = 0:
  - q <= mem[address]; array unchanged.
  - Read latency is exactly 1 cycle.
- Rising edge with reset_n high, wren = 1:
  - mem[address] <= data.
  - q <= data (read-during-write returns new data on the same edge).
- q holds its value between edges; it changes only on a rising edge or on reset.
- No handshake and no busy state; a new access is accepted every cycle. Back-to-back read/write to the same address is legal.
- Reset asserted mid-operation:
  - Any write on that edge is discarded.
  - Array and q return to reset values immediately.
  - Deassertion is synchronised externally; the first edge after release performs a normal access.
- Out-of-range addresses cannot occur (DEPTH = 2**ADDR_W).
- X on wren while reset_n is high: treated as no write, so the array is never corrupted.

Decomposition:
- Shared package `memoria_pkg`:
  - ADDR_W, DATA_W, DEPTH constants.
  - typedefs `mem_addr_t`, `mem_word_t`.
  - default initial image as a constant array `MEM_INIT`, shared with the cache bench so reference models agree.
- No sub-module; a single flat module (array, write decode, output register).

Test Plan:
- Reset then read all addresses 0..15 sequentially with wren = 0: q one cycle later equals MEM_INIT (addr 0 → 111, addr 12 → 101, addr 15 → 000).
- Write data = 110 to addr 5, then read addr 5: q = 110 on the write edge and on the read edge; addr 4 still reads 100.
- Write-back pattern as the cache issues it:
  - Write 010 to addr 0xB, next cycle read addr 0x3.
  - q = 010 then 111.
  - Addr 0xB reads back 010.
- Back-to-back writes to the same address (001 then 101 at addr 7), then read: q = 101.
- Assert reset_n low asynchronously between edges after several writes: q = 0 immediately; subsequent read of addr 5 returns 011 (image restored).
- Hold wren = 0 with a constant address for 4 cycles: q stable; the array is never modified.
